// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: multi-slot AES round-key cache controller.
//
// Keeps up to NUM_SLOTS expanded AES keys (128/192/256) in an external round-key memory,
// one 16-entry region per slot. A request either hits a slot that already holds the same key
// and length, or starts the external expansion engine and streams its subkeys into that
// slot's region.
//
// Optional feature: define KEY_EXP_TIMEOUT_EN to abort a fill when the engine stalls for
// TIMEOUT cycles between subkeys. Without it, COLLECT waits indefinitely.
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   req, req_slot, req_key,      request pulse (taken only when idle), target slot,
//   req_len                      MSB-aligned key, length code (01/10/11, 00 illegal)
//   flush                        invalidate all slots
//   busy, done, hit, err         status; hit/err qualify the one-cycle done pulse
//   eng_start, eng_key, eng_len  expansion engine launch and registered key/length
//   eng_valid, eng_idx,          engine subkey stream
//   eng_subkey
//   mem_we, mem_waddr, mem_wdata round-key memory write port, address {slot, idx}
//   slot_valid                   per-slot valid flags for the cipher core
module aes_key_sched_ctrl #(
   parameter int unsigned NUM_SLOTS = 2,
   parameter int unsigned SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  req,
   input  logic [SLOT_W-1:0]     req_slot,
   input  logic [255:0]          req_key,
   input  logic [1:0]            req_len,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic                  hit,
   output logic                  err,
   output logic                  eng_start,
   output logic [255:0]          eng_key,
   output logic [1:0]            eng_len,
   input  logic                  eng_valid,
   input  logic [3:0]            eng_idx,
   input  logic [127:0]          eng_subkey,
   output logic                  mem_we,
   output logic [SLOT_W+3:0]     mem_waddr,
   output logic [127:0]          mem_wdata,
   output logic [NUM_SLOTS-1:0]  slot_valid
);

   typedef enum logic [1:0] {StIdle, StCheck, StCollect, StDone} state_e;

   state_e               r_state, w_state_d;
   logic [SLOT_W-1:0]    r_slot;
   logic [255:0]         r_key;
   logic [1:0]           r_len;
   logic [3:0]           r_cnt, w_cnt_d;
   logic [NUM_SLOTS-1:0] r_valid, w_valid_d;
   logic [255:0]         r_key_mem [NUM_SLOTS];
   logic [1:0]           r_len_mem [NUM_SLOTS];
   logic                 r_hit, w_hit_d;
   logic                 r_err, w_err_d;
   logic                 r_flushed;

   logic                 w_bad_slot;
   logic [3:0]           w_last_idx;
   logic                 w_we;
   logic                 w_clr_slot;
   logic                 w_set_valid;
   logic                 w_start;

`ifdef KEY_EXP_TIMEOUT_EN
   localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
   logic [TMR_W-1:0] r_timer;
   // Restarts at 1 so r_timer equals the cycles elapsed since the last start/accepted subkey.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_timer <= '0;
      end else if (w_start || w_we) begin
         r_timer <= TMR_W'(1);
      end else if (r_state == StCollect) begin
         r_timer <= r_timer + TMR_W'(1);
      end
   end
`endif

   assign w_bad_slot = (32'(r_slot) >= NUM_SLOTS);

   always_comb begin
      unique case (r_len)
         2'b01:   w_last_idx = 4'd10;
         2'b10:   w_last_idx = 4'd12;
         2'b11:   w_last_idx = 4'd14;
         default: w_last_idx = 4'd0;
      endcase
   end

   always_comb begin
      w_state_d   = r_state;
      w_cnt_d     = r_cnt;
      w_hit_d     = r_hit;
      w_err_d     = r_err;
      w_we        = 1'b0;
      w_clr_slot  = 1'b0;
      w_set_valid = 1'b0;
      w_start     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (req) w_state_d = StCheck;
         end
         StCheck: begin
            if (r_len == 2'b00 || w_bad_slot) begin
               w_err_d   = 1'b1;
               w_state_d = StDone;
            end else if (r_valid[r_slot] && r_key_mem[r_slot] == r_key &&
                         r_len_mem[r_slot] == r_len) begin
               w_hit_d   = 1'b1;
               w_state_d = StDone;
            end else begin
               w_clr_slot = 1'b1;
               w_start    = 1'b1;
               w_cnt_d    = 4'd0;
               w_state_d  = StCollect;
            end
         end
         StCollect: begin
            if (eng_valid) begin
               if (eng_idx == r_cnt) begin
                  w_we    = 1'b1;
                  w_cnt_d = r_cnt + 4'd1;
                  if (r_cnt == w_last_idx) begin
                     // flush (now or earlier in this fill) keeps the slot invalid
                     w_set_valid = !r_flushed;
                     w_state_d   = StDone;
                  end
               end else begin
                  w_err_d   = 1'b1;
                  w_state_d = StDone;
               end
            end
`ifdef KEY_EXP_TIMEOUT_EN
            else if (32'(r_timer) >= TIMEOUT - 1) begin
               w_err_d   = 1'b1;
               w_state_d = StDone;
            end
`endif
         end
         StDone: begin
            w_hit_d   = 1'b0;
            w_err_d   = 1'b0;
            w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   // flush overrides any set in the same cycle
   always_comb begin
      w_valid_d = r_valid;
      if (w_clr_slot)  w_valid_d[r_slot] = 1'b0;
      if (w_set_valid) w_valid_d[r_slot] = 1'b1;
      if (flush)       w_valid_d = '0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= StIdle;
         r_slot    <= '0;
         r_key     <= '0;
         r_len     <= '0;
         r_cnt     <= '0;
         r_valid   <= '0;
         r_hit     <= 1'b0;
         r_err     <= 1'b0;
         r_flushed <= 1'b0;
         for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            r_key_mem[i] <= '0;
            r_len_mem[i] <= '0;
         end
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_valid <= w_valid_d;
         r_hit   <= w_hit_d;
         r_err   <= w_err_d;
         if (r_state == StIdle && req) begin
            r_slot <= req_slot;
            r_key  <= req_key;
            r_len  <= req_len;
         end
         if (w_start) begin
            r_key_mem[r_slot] <= r_key;
            r_len_mem[r_slot] <= r_len;
            r_flushed         <= 1'b0;
         end else if (r_state == StCollect && flush) begin
            r_flushed <= 1'b1;
         end
      end
   end

   assign busy       = (r_state != StIdle);
   assign done       = (r_state == StDone);
   assign hit        = r_hit;
   assign err        = r_err;
   assign eng_start  = w_start;
   assign eng_key    = r_key;
   assign eng_len    = r_len;
   assign mem_we     = w_we;
   assign mem_waddr  = {r_slot, r_cnt};
   assign mem_wdata  = w_we ? eng_subkey : '0;
   assign slot_valid = r_valid;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl (default build, NUM_SLOTS=2).
module tb_aes_key_sched_ctrl;

   localparam int SW = 1;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         req = 1'b0;
   logic [SW-1:0] req_slot = '0;
   logic [255:0] req_key = '0;
   logic [1:0]   req_len = '0;
   logic         flush = 1'b0;
   logic         busy, done, hit, err, eng_start;
   logic [255:0] eng_key;
   logic [1:0]   eng_len;
   logic         eng_valid = 1'b0;
   logic [3:0]   eng_idx = '0;
   logic [127:0] eng_subkey = '0;
   logic         mem_we;
   logic [SW+3:0] mem_waddr;
   logic [127:0] mem_wdata;
   logic [1:0]   slot_valid;

   aes_key_sched_ctrl #(.NUM_SLOTS(2)) dut (
      .clk(clk), .resetn(resetn), .req(req), .req_slot(req_slot), .req_key(req_key),
      .req_len(req_len), .flush(flush), .busy(busy), .done(done), .hit(hit), .err(err),
      .eng_start(eng_start), .eng_key(eng_key), .eng_len(eng_len), .eng_valid(eng_valid),
      .eng_idx(eng_idx), .eng_subkey(eng_subkey), .mem_we(mem_we), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata), .slot_valid(slot_valid)
   );

   always #5 clk = ~clk;

   localparam logic [255:0] KEY0   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] KEY256 =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};

   int total = 0;
   int bad = 0;
   int cyc = 0;

   // Monitor log (written only by the monitor)
   int          wr_cnt = 0;
   int          start_cnt = 0;
   int          done_n = 0;
   int          done_cyc = 0;
   int          stray = 0;
   logic        done_hit = 1'b0;
   logic        done_err = 1'b0;
   logic [4:0]  log_addr [128];
   logic [127:0] log_data [128];

   // Marks taken by the main flow
   int m_wr, m_st, m_dn, req_cyc;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mem_we) begin
         if (wr_cnt < 128) begin
            log_addr[wr_cnt] <= mem_waddr;
            log_data[wr_cnt] <= mem_wdata;
         end
         wr_cnt <= wr_cnt + 1;
      end
      if (eng_start) start_cnt <= start_cnt + 1;
      if (done) begin
         done_n   <= done_n + 1;
         done_hit <= hit;
         done_err <= err;
         done_cyc <= cyc;
      end else if (hit || err) begin
         stray <= stray + 1;
      end
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] sk(input int seed, input int i);
      return {8'(seed), 116'h0, 4'(i)};
   endfunction

   task automatic take_mark();
      m_wr = wr_cnt;
      m_st = start_cnt;
      m_dn = done_n;
   endtask

   task automatic send_req(input logic [SW-1:0] slot, input logic [255:0] key,
                           input logic [1:0] len);
      take_mark();
      @(posedge clk); #1;
      req = 1'b1; req_slot = slot; req_key = key; req_len = len;
      req_cyc = cyc;
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done_n == m_dn && n < 60) begin
         @(negedge clk); #1;
         n++;
      end
      if (done_n == m_dn) check("done_timeout", 256'(0), 256'(1));
      @(posedge clk); #1;
   endtask

   // Engine model: emits n subkeys starting the cycle after CHECK.
   task automatic emit(input int seed, input int n, input int skip_at, input int flush_at);
      int idx;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         idx = (skip_at >= 0 && i >= skip_at) ? i + 1 : i;
         eng_valid = 1'b1; eng_idx = 4'(idx); eng_subkey = sk(seed, idx);
         flush = (i == flush_at);
         if (i == 0) check("busy_collect", 256'(busy), 256'(1));
      end
      @(posedge clk); #1;
      eng_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic check_writes(input int base, input int seed, input int n);
      check("wr_count", 256'(wr_cnt - m_wr), 256'(n));
      for (int k = 0; k < n && (m_wr + k) < 128; k++) begin
         check("waddr", 256'(log_addr[m_wr + k]), 256'(base + k));
         check("wdata", 256'(log_data[m_wr + k]), 256'(sk(seed, k)));
      end
   endtask

   task automatic check_done(input logic e_hit, input logic e_err, input int e_starts);
      check("done_cnt", 256'(done_n - m_dn), 256'(1));
      check("hit", 256'(done_hit), 256'(e_hit));
      check("err", 256'(done_err), 256'(e_err));
      check("eng_start_cnt", 256'(start_cnt - m_st), 256'(e_starts));
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_busy", 256'(busy), 256'(0));
      check("rst_done", 256'(done), 256'(0));
      check("rst_hit_err", 256'({hit, err}), 256'(0));
      check("rst_start", 256'(eng_start), 256'(0));
      check("rst_we", 256'(mem_we), 256'(0));
      check("rst_valid", 256'(slot_valid), 256'(0));
      check("rst_eng_key", eng_key, 256'(0));
      check("rst_eng_len", 256'(eng_len), 256'(0));
      check("rst_waddr", 256'(mem_waddr), 256'(0));
      check("rst_wdata", 256'(mem_wdata), 256'(0));
      @(posedge clk); #1;
      resetn = 1'b1;

      // 128-bit fill into slot 0
      send_req(1'b0, KEY0, 2'b01);
      check("check_start", 256'(eng_start), 256'(1));
      check("eng_key", eng_key, KEY0);
      check("eng_len", 256'(eng_len), 256'(2'b01));
      emit(1, 11, -1, -1);
      wait_done();
      check_done(1'b0, 1'b0, 1);
      check_writes(16'h00, 1, 11);
      check("valid_after_fill0", 256'(slot_valid), 256'(2'b01));

      // Identical request hits, done 2 cycles after req
      send_req(1'b0, KEY0, 2'b01);
      wait_done();
      check_done(1'b1, 1'b0, 0);
      check("hit_latency", 256'(done_cyc - req_cyc), 256'(2));
      check("hit_no_write", 256'(wr_cnt - m_wr), 256'(0));

      // 256-bit fill into slot 1
      send_req(1'b1, KEY256, 2'b11);
      emit(2, 15, -1, -1);
      wait_done();
      check_done(1'b0, 1'b0, 1);
      check_writes(16'h10, 2, 15);
      check("valid_after_fill1", 256'(slot_valid), 256'(2'b11));

      // eng_valid while idle writes nothing
      take_mark();
      @(posedge clk); #1;
      eng_valid = 1'b1; eng_idx = 4'd0; eng_subkey = sk(9, 0);
      #1;
      check("idle_we", 256'(mem_we), 256'(0));
      @(posedge clk); #1;
      eng_valid = 1'b0;
      @(posedge clk); #1;
      check("idle_no_write", 256'(wr_cnt - m_wr), 256'(0));

      // slot 0 still cached after the slot 1 fill
      send_req(1'b0, KEY0, 2'b01);
      wait_done();
      check_done(1'b1, 1'b0, 0);

      // Illegal length
      send_req(1'b1, KEY256, 2'b00);
      wait_done();
      check_done(1'b0, 1'b1, 0);
      check("valid_after_illegal", 256'(slot_valid), 256'(2'b11));

      // flush mid-fill (with idx 6): fill completes, nothing valid at the end
      send_req(1'b0, KEY192, 2'b10);
      emit(3, 13, -1, 6);
      wait_done();
      check_done(1'b0, 1'b0, 1);
      check_writes(16'h00, 3, 13);
      check("valid_after_flush", 256'(slot_valid), 256'(2'b00));

      // Out-of-order index: idx 0,1,3
      send_req(1'b1, KEY0, 2'b01);
      emit(4, 3, 2, -1);
      wait_done();
      check_done(1'b0, 1'b1, 1);
      check_writes(16'h10, 4, 2);
      check("valid_after_badidx", 256'(slot_valid), 256'(2'b00));

      // Refill slot 0; a req during the fill is ignored
      send_req(1'b0, KEY0, 2'b01);
      @(posedge clk); #1;
      req = 1'b1; req_slot = 1'b1; req_key = KEY256; req_len = 2'b11;
      @(posedge clk); #1;
      req = 1'b0;
      check("busy_req_ignored_len", 256'(eng_len), 256'(2'b01));
      emit(5, 11, -1, -1);
      wait_done();
      check_done(1'b0, 1'b0, 1);
      check_writes(16'h00, 5, 11);
      check("valid_after_refill", 256'(slot_valid), 256'(2'b01));

      // Asynchronous reset mid-fill
      send_req(1'b1, KEY256, 2'b11);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         eng_valid = 1'b1; eng_idx = 4'(i); eng_subkey = sk(6, i);
      end
      #2;
      resetn = 1'b0;
      #1;
      check("midrst_busy", 256'(busy), 256'(0));
      check("midrst_we", 256'(mem_we), 256'(0));
      check("midrst_valid", 256'(slot_valid), 256'(0));
      check("midrst_eng_len", 256'(eng_len), 256'(0));
      eng_valid = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;

      check("stray_hit_err", 256'(stray), 256'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
